// File: rtl/mlu_op_feeder.sv
// Operand sequencer for the MLU. Streams one hot vector against a run of cold
// vectors and hands back one accumulated result per cold vector.
module mlu_op_feeder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 10,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned PIPE_LAT   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       hot_base,
  input  logic [ADDR_WIDTH-1:0]       cold_base,
  input  logic [LEN_WIDTH-1:0]        num_beats,
  input  logic [LEN_WIDTH-1:0]        num_vec,
  output logic                        busy,
  output logic                        done,
  output logic                        hot_rd_en,
  output logic                        cold_rd_en,
  output logic [ADDR_WIDTH-1:0]       hot_rd_addr,
  output logic [ADDR_WIDTH-1:0]       cold_rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0] hot_rd_data,
  input  logic [LANES*DATA_WIDTH-1:0] cold_rd_data,
  output logic [LANES*DATA_WIDTH-1:0] hot_in,
  output logic [LANES*DATA_WIDTH-1:0] cold_in,
  output logic                        op_valid,
  output logic                        clear_reg,
  output logic                        isStop,
  output logic                        is_start,
  input  logic [ACC_WIDTH-1:0]        acc_result,
  output logic [ACC_WIDTH-1:0]        res_data,
  output logic [LEN_WIDTH-1:0]        res_index,
  output logic                        res_valid,
  input  logic                        res_ready
);

  localparam int unsigned DRAIN_LEN = 2 + PIPE_LAT;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] hot_base_q;
  logic [ADDR_WIDTH-1:0] cold_ptr;
  logic [LEN_WIDTH-1:0]  num_beats_q;
  logic [LEN_WIDTH-1:0]  num_vec_q;
  logic [LEN_WIDTH-1:0]  beat;
  logic [LEN_WIDTH-1:0]  beat_nxt;
  logic [LEN_WIDTH-1:0]  vec;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  rd_pend;

  assign beat_nxt = beat + LEN_WIDTH'(1);

  // Job sequencing: clear, stream num_beats reads, drain the MLU pipe, hand off result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      hot_base_q   <= '0;
      cold_ptr     <= '0;
      num_beats_q  <= '0;
      num_vec_q    <= '0;
      beat         <= '0;
      vec          <= '0;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      hot_rd_en    <= 1'b0;
      cold_rd_en   <= 1'b0;
      hot_rd_addr  <= '0;
      cold_rd_addr <= '0;
      clear_reg    <= 1'b0;
      is_start     <= 1'b0;
      res_data     <= '0;
      res_index    <= '0;
      res_valid    <= 1'b0;
    end else begin
      done      <= 1'b0;
      clear_reg <= 1'b0;
      is_start  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            hot_base_q  <= hot_base;
            num_beats_q <= num_beats;
            num_vec_q   <= num_vec;
            if (num_beats == '0 || num_vec == '0) begin
              done <= 1'b1;
            end else begin
              state     <= S_CLEAR;
              busy      <= 1'b1;
              clear_reg <= 1'b1;
              vec       <= '0;
              cold_ptr  <= cold_base;
            end
          end
        end
        S_CLEAR: begin
          state        <= S_STREAM;
          beat         <= '0;
          hot_rd_en    <= 1'b1;
          cold_rd_en   <= 1'b1;
          hot_rd_addr  <= hot_base_q;
          cold_rd_addr <= cold_ptr;
        end
        S_STREAM: begin
          if (beat_nxt == num_beats_q) begin
            state      <= S_DRAIN;
            hot_rd_en  <= 1'b0;
            cold_rd_en <= 1'b0;
            cold_ptr   <= cold_ptr + ADDR_WIDTH'(num_beats_q);
            drain_cnt  <= '0;
          end else begin
            beat         <= beat_nxt;
            hot_rd_addr  <= hot_base_q + ADDR_WIDTH'(beat_nxt);
            cold_rd_addr <= cold_ptr + ADDR_WIDTH'(beat_nxt);
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DRAIN_W'(1);
          // is_start is high in the very cycle acc_result is sampled
          if (drain_cnt == DRAIN_W'(DRAIN_LEN - 2)) is_start <= 1'b1;
          if (drain_cnt == DRAIN_W'(DRAIN_LEN - 1)) begin
            state     <= S_OUT;
            res_valid <= 1'b1;
            res_data  <= acc_result;
            res_index <= vec;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (vec == num_vec_q - LEN_WIDTH'(1)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= S_CLEAR;
              vec       <= vec + LEN_WIDTH'(1);
              clear_reg <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand path: data returns one cycle after rd_en, registered to the MLU one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      op_valid <= 1'b0;
      isStop   <= 1'b0;
      hot_in   <= '0;
      cold_in  <= '0;
    end else begin
      rd_pend  <= hot_rd_en;
      op_valid <= rd_pend;
      isStop   <= !rd_pend;
      if (rd_pend) begin
        hot_in  <= hot_rd_data;
        cold_in <= cold_rd_data;
      end
    end
  end

endmodule
